// File: rtl/dmem_arbiter_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | dmem_arbiter_if                                                      |
// | Two requester ports plus the byte-lane memory side of dmem_arbiter.  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
interface dmem_arbiter_if #(
  parameter int ADDR_W = 32
);
  logic              req0;
  logic              req1;
  logic [ADDR_W-1:0] addr0;
  logic [ADDR_W-1:0] addr1;
  logic [3:0]        wren0;
  logic [3:0]        wren1;
  logic [31:0]       wdata0;
  logic [31:0]       wdata1;
  logic              gnt0;
  logic              gnt1;
  logic              rvalid0;
  logic              rvalid1;
  logic [31:0]       rdata0;
  logic [31:0]       rdata1;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [3:0]        mem_wren;
  logic [31:0]       mem_rdata;

  modport slave (
    input  req0, req1, addr0, addr1, wren0, wren1, wdata0, wdata1, mem_rdata,
    output gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1,
           mem_addr, mem_wdata, mem_wren
  );

  // Requesters and the memory model together form the far side.
  modport master (
    output req0, req1, addr0, addr1, wren0, wren1, wdata0, wdata1, mem_rdata,
    input  gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1,
           mem_addr, mem_wdata, mem_wren
  );
endinterface
`default_nettype wire

// File: rtl/dmem_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | dmem_arbiter                                                         |
// | Two-port data-memory arbiter, IDLE/GRANT/RESP, one access per 2 clk. |
// | Option: DMEM_ARB_ROUND_ROBIN_EN selects round-robin over fixed prio. |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module dmem_arbiter #(
  parameter int ADDR_W = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  dmem_arbiter_if.slave   bus
);

  localparam logic [1:0] c_IDLE  = 2'd0;
  localparam logic [1:0] c_GRANT = 2'd1;
  localparam logic [1:0] c_RESP  = 2'd2;

  logic [1:0]        r_state;
  logic              r_owner;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_wdata;
  logic [3:0]        r_wren;
  logic [31:0]       r_rdata0;
  logic [31:0]       r_rdata1;

  logic              w_arb;
  logic              w_win1;

  // Arbitration happens at any edge leaving IDLE or RESP with a pending request.
  assign w_arb = (bus.req0 | bus.req1) & ((r_state == c_IDLE) | (r_state == c_RESP));

`ifdef DMEM_ARB_ROUND_ROBIN_EN
  logic r_last;

  // r_last = 1 means port 1 was granted last, so port 0 is favoured.
  assign w_win1 = bus.req1 & (~bus.req0 | ~r_last);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last <= 1'b1;
    end else if (w_arb) begin
      r_last <= w_win1;
    end
  end
`else
  assign w_win1 = bus.req1 & ~bus.req0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= c_IDLE;
      r_owner <= 1'b0;
      r_addr  <= '0;
      r_wdata <= 32'h0;
      r_wren  <= 4'h0;
    end else begin
      case (r_state)
        c_IDLE, c_RESP: begin
          if (w_arb) begin
            r_state <= c_GRANT;
            r_owner <= w_win1;
            r_addr  <= w_win1 ? bus.addr1  : bus.addr0;
            r_wdata <= w_win1 ? bus.wdata1 : bus.wdata0;
            r_wren  <= w_win1 ? bus.wren1  : bus.wren0;
          end else begin
            r_state <= c_IDLE;
          end
        end
        c_GRANT: r_state <= c_RESP;
        default: r_state <= c_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rdata0 <= 32'h0;
      r_rdata1 <= 32'h0;
    end else if ((r_state == c_GRANT) && (r_wren == 4'h0)) begin
      if (r_owner) begin
        r_rdata1 <= bus.mem_rdata;
      end else begin
        r_rdata0 <= bus.mem_rdata;
      end
    end
  end

  assign bus.gnt0    = (r_state == c_GRANT) & ~r_owner;
  assign bus.gnt1    = (r_state == c_GRANT) &  r_owner;
  assign bus.rvalid0 = (r_state == c_RESP)  & ~r_owner;
  assign bus.rvalid1 = (r_state == c_RESP)  &  r_owner;
  assign bus.rdata0  = r_rdata0;
  assign bus.rdata1  = r_rdata1;

  // Address/data registers only change on arbitration, so they hold outside GRANT.
  assign bus.mem_addr  = r_addr;
  assign bus.mem_wdata = r_wdata;
  assign bus.mem_wren  = (r_state == c_GRANT) ? r_wren : 4'h0;

endmodule
`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_dmem_arbiter                                                      |
// | Directed self-checking bench for dmem_arbiter with a byte-lane memory.|
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_dmem_arbiter;

`ifdef DMEM_ARB_ROUND_ROBIN_EN
  localparam bit c_RR = 1'b1;
`else
  localparam bit c_RR = 1'b0;
`endif

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  int   wr_cycles;
  int   wr_snap;
  logic e_g0, e_g1, e_v0, e_v1;

  logic [31:0] mem [0:255];

  dmem_arbiter_if #(.ADDR_W(32)) bus ();

  dmem_arbiter #(.ADDR_W(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: combinational read, byte-lane write on the clock edge.
  assign bus.mem_rdata = mem[bus.mem_addr[7:0]];

  always @(posedge clk) begin
    if (!rst_n) begin
      mem[8'h10] <= 32'hDEAD_BEEF;
      mem[8'h20] <= 32'h1122_3344;
      mem[8'h30] <= 32'h0000_0000;
      mem[8'h40] <= 32'hCAFE_F00D;
    end else if (bus.mem_wren != 4'h0) begin
      wr_cycles <= wr_cycles + 1;
      for (int n = 0; n < 4; n++) begin
        if (bus.mem_wren[n]) mem[bus.mem_addr[7:0]][8*n +: 8] <= bus.mem_wdata[8*n +: 8];
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    wr_cycles = 0;
    rst_n     = 1'b0;
    bus.req0 = 1'b0; bus.addr0 = '0; bus.wren0 = 4'h0; bus.wdata0 = 32'h0;
    bus.req1 = 1'b0; bus.addr1 = '0; bus.wren1 = 4'h0; bus.wdata1 = 32'h0;

    // Reset state
    tick(); tick();
    chk("rst_gnt",    {30'h0, bus.gnt1, bus.gnt0}, 32'h0);
    chk("rst_rvalid", {30'h0, bus.rvalid1, bus.rvalid0}, 32'h0);
    chk("rst_wren",   {28'h0, bus.mem_wren}, 32'h0);
    chk("rst_rdata0", bus.rdata0, 32'h0);
    chk("rst_rdata1", bus.rdata1, 32'h0);
    chk("rst_maddr",  bus.mem_addr, 32'h0);
    chk("rst_mwdata", bus.mem_wdata, 32'h0);
    rst_n = 1'b1;
    tick();

    // Single read on port 0
    bus.req0 = 1'b1; bus.addr0 = 32'h10; bus.wren0 = 4'h0;
    tick();
    chk("rd_gnt0",   {31'h0, bus.gnt0}, 32'h1);
    chk("rd_gnt1",   {31'h0, bus.gnt1}, 32'h0);
    chk("rd_maddr",  bus.mem_addr, 32'h10);
    chk("rd_mwren",  {28'h0, bus.mem_wren}, 32'h0);
    bus.req0 = 1'b0;
    tick();
    chk("rd_rvalid0", {31'h0, bus.rvalid0}, 32'h1);
    chk("rd_gnt0_lo", {31'h0, bus.gnt0}, 32'h0);
    chk("rd_rdata0",  bus.rdata0, 32'hDEAD_BEEF);
    tick();
    chk("rd_idle",    {31'h0, bus.rvalid0}, 32'h0);

    // Byte write on port 1, lane 1
    wr_snap = wr_cycles;
    bus.req1 = 1'b1; bus.addr1 = 32'h20; bus.wren1 = 4'b0010; bus.wdata1 = 32'hAABB_CCDD;
    tick();
    chk("wr_gnt1",   {31'h0, bus.gnt1}, 32'h1);
    chk("wr_mwren",  {28'h0, bus.mem_wren}, 32'h2);
    chk("wr_mwdata", bus.mem_wdata, 32'hAABB_CCDD);
    bus.req1 = 1'b0;
    tick();
    chk("wr_rvalid1", {31'h0, bus.rvalid1}, 32'h1);
    chk("wr_mwren_lo", {28'h0, bus.mem_wren}, 32'h0);
    chk("wr_rdata1_hold", bus.rdata1, 32'h0);
    chk("wr_maddr_hold", bus.mem_addr, 32'h20);
    tick();
    chk("wr_once", wr_cycles - wr_snap, 32'h1);

    // Read back on port 1
    bus.req1 = 1'b1; bus.wren1 = 4'h0;
    tick();
    chk("rb_gnt1", {31'h0, bus.gnt1}, 32'h1);
    bus.req1 = 1'b0;
    tick();
    chk("rb_rdata1", bus.rdata1, 32'h1122_CC44);
    tick();

    // Continuous contention
    bus.req0 = 1'b1; bus.addr0 = 32'h10; bus.wren0 = 4'h0;
    bus.req1 = 1'b1; bus.addr1 = 32'h20; bus.wren1 = 4'h0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (i % 2 == 0) begin
        e_g0 = c_RR ? (i % 4 == 0) : 1'b1;
        e_g1 = c_RR ? (i % 4 == 2) : 1'b0;
        e_v0 = 1'b0; e_v1 = 1'b0;
      end else begin
        e_g0 = 1'b0; e_g1 = 1'b0;
        e_v0 = c_RR ? (i % 4 == 1) : 1'b1;
        e_v1 = c_RR ? (i % 4 == 3) : 1'b0;
      end
      chk($sformatf("ct_gnt_%0d", i),    {30'h0, bus.gnt1, bus.gnt0}, {30'h0, e_g1, e_g0});
      chk($sformatf("ct_rvalid_%0d", i), {30'h0, bus.rvalid1, bus.rvalid0}, {30'h0, e_v1, e_v0});
    end
    chk("ct_rdata0", bus.rdata0, 32'hDEAD_BEEF);
    bus.req0 = 1'b0; bus.req1 = 1'b0;
    tick();
    chk("ct_idle", {30'h0, bus.gnt1, bus.gnt0}, 32'h0);
    tick();

    // Reset during GRANT of a full-word write
    bus.req0 = 1'b1; bus.addr0 = 32'h30; bus.wren0 = 4'hF; bus.wdata0 = 32'h5566_7788;
    tick();
    chk("mr_mwren", {28'h0, bus.mem_wren}, 32'hF);
    #1 rst_n = 1'b0;
    #1;
    chk("mr_mwren_async", {28'h0, bus.mem_wren}, 32'h0);
    chk("mr_gnt0_async",  {31'h0, bus.gnt0}, 32'h0);
    bus.req0 = 1'b0; bus.wren0 = 4'h0;
    tick();
    chk("mr_rvalid0", {31'h0, bus.rvalid0}, 32'h0);
    chk("mr_rdata0",  bus.rdata0, 32'h0);
    rst_n = 1'b1;
    tick();
    chk("mr_rvalid0_post", {31'h0, bus.rvalid0}, 32'h0);
    chk("mr_no_write", mem[8'h30], 32'h0);

    // First arbitration after reset favours port 0; high address passes through
    bus.req0 = 1'b1; bus.addr0 = 32'hFFFF_FF10; bus.wren0 = 4'h0;
    bus.req1 = 1'b1; bus.addr1 = 32'h20;        bus.wren1 = 4'h0;
    tick();
    chk("pr_gnt", {30'h0, bus.gnt1, bus.gnt0}, 32'h1);
    chk("pr_maddr", bus.mem_addr, 32'hFFFF_FF10);
    bus.req0 = 1'b0; bus.req1 = 1'b0;
    tick();
    chk("pr_rdata0", bus.rdata0, 32'hDEAD_BEEF);
    tick();

    // Withdrawn request between edges
    wr_snap = wr_cycles;
    bus.addr1 = 32'h40; bus.wren1 = 4'hF; bus.wdata1 = 32'h0BAD_0BAD;
    #2 bus.req1 = 1'b1;
    #3 bus.req1 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("wd_gnt_%0d", i), {30'h0, bus.gnt1, bus.gnt0}, 32'h0);
    end
    chk("wd_no_wr", wr_cycles - wr_snap, 32'h0);
    chk("wd_mem",   mem[8'h40], 32'hCAFE_F00D);

    // Still idle: a fresh request is granted one cycle later
    bus.req0 = 1'b1; bus.addr0 = 32'h10; bus.wren0 = 4'h0;
    tick();
    chk("wd_idle_gnt0", {31'h0, bus.gnt0}, 32'h1);
    bus.req0 = 1'b0;
    tick(); tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Exclusivity of the one-hot outputs, every cycle
  always @(negedge clk) begin
    if (rst_n) begin
      chk("excl_gnt",    {31'h0, bus.gnt0 & bus.gnt1}, 32'h0);
      chk("excl_rvalid", {31'h0, bus.rvalid0 & bus.rvalid1}, 32'h0);
    end
  end

endmodule
`default_nettype wire
